// File: rtl/burst_counter.sv
// burst_counter: enable-gated modulo-MAX counter producing a sequential
// address per accepted word and a registered one-cycle done pulse at the
// end of each MAX-word block.
// Optional macro BURST_COUNTER_CHECK_EN adds simulation-only $error checks
// (parameter range, X/Z on ena/cnt outside reset, cnt out of range); it has
// no functional effect.
module burst_counter #(
  parameter int CW  = 16,
  parameter int MAX = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  output logic [CW-1:0] cnt,
  output logic          done
);

  // Terminal value held one bit wider so MAX == 2^CW does not overflow.
  localparam logic [CW:0] LAST = (CW+1)'(MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          term;

  assign term = ({1'b0, cnt_q} == LAST);

  // Next-state: advance or wrap on ena, pulse done only on a terminal accept.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (ena) begin
      if (term) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

`ifdef BURST_COUNTER_CHECK_EN
  // Simulation-only sanity checks; they never alter state.
  always_ff @(posedge clk) begin
    if (MAX < 1 || longint'(MAX) > (longint'(1) << CW))
      $error("burst_counter: MAX=%0d outside 1..2^%0d", MAX, CW);
    if (!rst && ($isunknown(ena) || $isunknown(cnt_q)))
      $error("burst_counter: unknown value on ena or cnt");
    if ({1'b0, cnt_q} > LAST)
      $error("burst_counter: cnt=%0d not below MAX=%0d", cnt_q, MAX);
  end
`endif

endmodule

// File: tb/tb_burst_counter.sv
// Directed testbench for burst_counter: four instances (MAX=8, 4, 1, 16,
// all CW=4) share clk/rst and each gets its own ena.
module tb_burst_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena8, ena4, ena1, ena16;
  logic [3:0] cnt8, cnt4, cnt1, cnt16;
  logic       done8, done4, done1, done16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  burst_counter #(.CW(4), .MAX(8))  u8  (.clk(clk), .rst(rst), .ena(ena8),  .cnt(cnt8),  .done(done8));
  burst_counter #(.CW(4), .MAX(4))  u4  (.clk(clk), .rst(rst), .ena(ena4),  .cnt(cnt4),  .done(done4));
  burst_counter #(.CW(4), .MAX(1))  u1  (.clk(clk), .rst(rst), .ena(ena1),  .cnt(cnt1),  .done(done1));
  burst_counter #(.CW(4), .MAX(16)) u16 (.clk(clk), .rst(rst), .ena(ena16), .cnt(cnt16), .done(done16));

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gapped-enable vectors for MAX=8 with expected values after each edge.
  logic gap_ena  [11] = '{1,0,1,1,0,0,1,1,1,1,1};
  int   gap_cnt  [11] = '{1,1,2,3,3,3,4,5,6,7,0};
  int   gap_done [11] = '{0,0,0,0,0,0,0,0,0,0,1};
  logic m1_ena   [4]  = '{1,1,0,1};

  initial begin
    rst = 1'b1; ena8 = 1'b0; ena4 = 1'b0; ena1 = 1'b0; ena16 = 1'b0;

    // Reset held for 3 cycles, then 10 idle cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_cnt8", cnt8, 0);
      check("rst_done8", done8, 0);
    end
    check("rst_cnt16", cnt16, 0);
    check("rst_done1", done1, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_cnt8", cnt8, 0);
      check("idle_done8", done8, 0);
    end

    // Continuous block, MAX=8.
    ena8 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("cont_cnt8", cnt8, i % 8);
      check("cont_done8", done8, (i == 8) ? 1 : 0);
    end
    ena8 = 1'b0;
    step();
    check("cont_hold_cnt8", cnt8, 0);
    check("cont_fall_done8", done8, 0);

    // Gapped enable, MAX=8.
    for (int i = 0; i < 11; i++) begin
      ena8 = gap_ena[i];
      step();
      check("gap_cnt8", cnt8, gap_cnt[i]);
      check("gap_done8", done8, gap_done[i]);
    end
    ena8 = 1'b0;
    step();
    check("gap_fall_done8", done8, 0);

    // Back-to-back blocks, MAX=4.
    ena4 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("b2b_cnt4", cnt4, i % 4);
      check("b2b_done4", done4, (i % 4 == 0) ? 1 : 0);
    end
    ena4 = 1'b0;
    step();
    check("b2b_fall_done4", done4, 0);

    // Mid-block reset, MAX=8.
    ena8 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mid_pre_cnt8", cnt8, 5);
    rst = 1'b1;
    step();
    check("mid_rst_cnt8", cnt8, 0);
    check("mid_rst_done8", done8, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("mid_cnt8", cnt8, i % 8);
      check("mid_done8", done8, (i == 8) ? 1 : 0);
    end
    ena8 = 1'b0;
    step();
    check("mid_fall_done8", done8, 0);

    // MAX=1: done is ena delayed one cycle, cnt stays 0.
    for (int i = 0; i < 4; i++) begin
      ena1 = m1_ena[i];
      step();
      check("m1_done1", done1, int'(m1_ena[i]));
      check("m1_cnt1", cnt1, 0);
    end
    ena1 = 1'b0;
    step();
    check("m1_fall_done1", done1, 0);

    // MAX=16, CW=4: full-range wrap 15 -> 0.
    ena16 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("full_cnt16", cnt16, i % 16);
      check("full_done16", done16, (i == 16) ? 1 : 0);
    end
    ena16 = 1'b0;
    step();
    check("full_hold_cnt16", cnt16, 0);
    check("full_fall_done16", done16, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
